// File: rtl/factorial_pkg.sv
// Shared constants for the factorial BCD converter: state encoding,
// operand width derivation and the minimum digit-count rule.
package factorial_pkg;

  localparam int NUM_DIGITS_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int operand_width(input int n);
    return 20 * n;
  endfunction

  // ceil(w * log10(2)) with log10(2) approximated as 0.30103
  function automatic int min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/factorial_bcd_converter_if.sv
// Handshake bundle between the factorial block, the converter and the display driver.
interface factorial_bcd_converter_if
  import factorial_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 25
);
  logic                    in_valid;
  logic                    in_ready;
  logic [20*N-1:0]         bin_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*DIGITS-1:0]     bcd_out;
  logic [NUM_DIGITS_W-1:0] num_digits;
  logic                    busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, num_digits, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, num_digits, busy
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 before the shift.
module bcd_add3_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/factorial_bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per cycle) with significant
// digit count, valid/ready on both sides.
module factorial_bcd_converter
  import factorial_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 25
) (
  input logic                        clk,
  input logic                        rst,
  factorial_bcd_converter_if.slave   bus
);
  localparam int W  = operand_width(N);
  localparam int CW = $clog2(W + 1);

  state_t                  r_state;
  state_t                  r_state_next;
  logic [W-1:0]            r_shift;
  logic [4*DIGITS-1:0]     r_acc;
  logic [CW-1:0]           r_cnt;
  logic [4*DIGITS-1:0]     r_bcd;
  logic [NUM_DIGITS_W-1:0] r_nd;
  logic [4*DIGITS-1:0]     w_adj;
  logic [NUM_DIGITS_W-1:0] w_num_digits;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_busy;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_add3_digit u_add3 (
        .i_digit(r_acc[4*gi +: 4]),
        .o_digit(w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Leading non-zero digit search; an all-zero result still shows one digit.
  always_comb begin
    w_num_digits = NUM_DIGITS_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] != 4'd0) w_num_digits = NUM_DIGITS_W'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) r_state_next = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == CW'(1)) r_state_next = COUNT;
      end
      COUNT: r_state_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) r_state_next = IDLE;
      end
      default: r_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_nd    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_shift <= bus.bin_in;
            r_acc   <= '0;
            r_cnt   <= CW'(W);
          end
        end
        SHIFT: begin
          {r_acc, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt - CW'(1);
        end
        COUNT: begin
          r_bcd <= r_acc;
          r_nd  <= w_num_digits;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.bcd_out    = r_bcd;
  assign bus.num_digits = r_nd;

endmodule

// File: tb/tb_factorial_bcd_converter.sv
// Directed vector bench for the BCD converter: table of conversions plus
// backpressure and mid-operation reset sequences.
module tb_factorial_bcd_converter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  factorial_bcd_converter_if #(.N(4), .DIGITS(25)) bus ();

  factorial_bcd_converter #(.N(4), .DIGITS(25)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bin;
    logic [99:0] bcd;
    logic [4:0]  nd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [79:0] v);
    @(negedge clk);
    chk("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_op(input logic [99:0] exp_bcd);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", 128'(bus.out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(bus.in_ready), 128'(1));
    chk("bcd_held_after_hs", 128'(bus.bcd_out), 128'(exp_bcd));
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    start_op(v.bin);
    wait_done(k);
    chk("latency", 128'(k), 128'(81));
    chk("bcd_out", 128'(bus.bcd_out), 128'(v.bcd));
    chk("num_digits", 128'(bus.num_digits), 128'(v.nd));
    chk("in_ready_in_done", 128'(bus.in_ready), 128'(0));
    chk("busy_in_done", 128'(bus.busy), 128'(1));
    $display("conv bin=%0d bcd=%0h nd=%0d latency=%0d", v.bin, bus.bcd_out, bus.num_digits, k);
    finish_op(v.bcd);
  endtask

  initial begin
    int k;
    vec_t v;
    total = 0;
    bad   = 0;
    vecs[0] = '{80'd0,             100'h0,             5'd1};
    vecs[1] = '{80'd120,           100'h120,           5'd3};
    vecs[2] = '{80'd1307674368000, 100'h1307674368000, 5'd13};
    vecs[3] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 100'h1208925819614629174706175, 5'd25};
    vecs[4] = '{80'd9,             100'h9,             5'd1};
    vecs[5] = '{80'd10,            100'h10,            5'd2};
    vecs[6] = '{80'd3628800,       100'h3628800,       5'd7};
    vecs[7] = '{80'd720,           100'h720,           5'd3};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_bcd", 128'(bus.bcd_out), 128'(0));
    chk("rst_nd", 128'(bus.num_digits), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: hold DONE for 10 cycles while wiggling the input side
    start_op(80'd3628800);
    wait_done(k);
    chk("bp_latency", 128'(k), 128'(81));
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = c[0];
      bus.bin_in   = 80'(c * 12345 + 7);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_bcd", 128'(bus.bcd_out), 128'(100'h3628800));
      chk("bp_nd", 128'(bus.num_digits), 128'(7));
    end
    $display("backpressure held bcd=%0h nd=%0d", bus.bcd_out, bus.num_digits);
    bus.in_valid = 1'b0;
    finish_op(100'h3628800);
    v = '{80'd120, 100'h120, 5'd3};
    run_vec(v);

    // Asynchronous reset 20 cycles into SHIFT
    start_op(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_bcd", 128'(bus.bcd_out), 128'(0));
    chk("mid_rst_nd", 128'(bus.num_digits), 128'(0));
    $display("mid-operation reset applied in_ready=%0b busy=%0b", bus.in_ready, bus.busy);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
